hpgp_itl_pingpong: RTL and testbench

//  Double-buffered HPGP turbo channel interleaver supporting all three PB sizes (PB16/PB136/PB520).
//  One bank is filled with systematic symbol pairs while the other drains as {systematic, interleaved} pairs.

---
 rtl/hpgp_itl_pkg.sv | 62 ++++++
 rtl/hpgp_itl_bank_ram.sv | 48 ++++
 rtl/hpgp_itl_pingpong.sv | 217 +++++++++++++++++++++
 tb/tb_hpgp_itl_pingpong.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpgp_itl_pkg.sv
// Shared types and constants for the HPGP turbo channel interleaver.
// Holds the PB-size encodings, per-size frame length and permutation-table base,
// the bank-state encoding, and the permutation table itself. The table is
// generated by itl_rom() as a fixed function of the table address, so no
// external ROM image is loaded. Each PB size uses an affine permutation
// (step*i + off) mod len, with step coprime to len.
package hpgp_itl_pkg;

    typedef enum logic [1:0] {
        MODE_PB16  = 2'd0,
        MODE_PB136 = 2'd1,
        MODE_PB520 = 2'd2,
        MODE_RSVD  = 2'd3
    } pb_mode_e;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_st_e;

    localparam int unsigned PB_LEN   [3] = '{64, 544, 2080};
    localparam int unsigned PB_BASE  [3] = '{0, 64, 608};
    localparam int unsigned ITL_STEP [3] = '{13, 31, 97};
    localparam int unsigned ITL_OFF  [3] = '{5, 11, 29};

    // Frame length in symbols; the reserved code never reaches a bank.
    function automatic int unsigned pb_len(input logic [1:0] m);
        case (m)
            MODE_PB136: return PB_LEN[1];
            MODE_PB520: return PB_LEN[2];
            default:    return PB_LEN[0];
        endcase
    endfunction

    // Offset of this PB size's segment in the concatenated table.
    function automatic int unsigned pb_base(input logic [1:0] m);
        case (m)
            MODE_PB136: return PB_BASE[1];
            MODE_PB520: return PB_BASE[2];
            default:    return PB_BASE[0];
        endcase
    endfunction

    // Table lookup: the segment is decoded from the address, entry is bank-relative.
    function automatic int unsigned itl_rom(input int unsigned addr);
        int unsigned base;
        int unsigned len;
        int unsigned step;
        int unsigned off;
        if (addr >= PB_BASE[2]) begin
            base = PB_BASE[2]; len = PB_LEN[2]; step = ITL_STEP[2]; off = ITL_OFF[2];
        end else if (addr >= PB_BASE[1]) begin
            base = PB_BASE[1]; len = PB_LEN[1]; step = ITL_STEP[1]; off = ITL_OFF[1];
        end else begin
            base = PB_BASE[0]; len = PB_LEN[0]; step = ITL_STEP[0]; off = ITL_OFF[0];
        end
        return (step * (addr - base) + off) % len;
    endfunction

endpackage

// File: rtl/hpgp_itl_bank_ram.sv
// Two-bank symbol store: one write port and two synchronous read ports.
// Addresses are {bank, idx}. Read data registers update only when rd_en is
// high, so the read stage freezes together with the output pipeline.
// Ports:
//   clk, n_rst            clock, async active-low reset (read registers only)
//   wr_en/wr_addr/wr_data write port
//   rd_en                 read-register enable (low while downstream stalls)
//   rd_addr_a/rd_data_a   systematic read port
//   rd_addr_b/rd_data_b   interleaved read port
module hpgp_itl_bank_ram #(
    parameter int unsigned D_WIDTH = 2,
    parameter int unsigned A_WIDTH = 12
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               wr_en,
    input  logic [A_WIDTH:0]   wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [A_WIDTH:0]   rd_addr_a,
    input  logic [A_WIDTH:0]   rd_addr_b,
    output logic [D_WIDTH-1:0] rd_data_a,
    output logic [D_WIDTH-1:0] rd_data_b
);

    localparam int unsigned DEPTH = 2 ** (A_WIDTH + 1);

    logic [D_WIDTH-1:0] mem [DEPTH];

    // Storage array carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read registers are reset so the outputs they drive are 0 after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
    end

endmodule

// File: rtl/hpgp_itl_pingpong.sv
// Double-buffered HPGP turbo channel interleaver (PB16/PB136/PB520).
// One bank fills with input symbols while the other drains as
// {systematic, interleaved} pairs through a 2-stage read pipeline that stalls
// as a unit under output back-pressure.
// Optional build macro HPGP_ITL_PAIR_SWAP_EN: when defined, the interleaved
// symbol has its bits reversed on even output indices.
// Ports:
//   clk, n_rst                  clock, async active-low reset
//   mode                        PB size, latched per bank on a frame's first beat
//   din, din_vld, din_rdy       input symbol stream
//   dout_sys, dout_itl          natural-order and interleaved symbols
//   dout_vld, dout_rdy          output handshake
//   dout_sof, dout_eof          first/last beat of a frame
//   err_mode                    pulse per cycle a frame start is offered with reserved mode
module hpgp_itl_pingpong
    import hpgp_itl_pkg::*;
#(
    parameter int unsigned D_WIDTH = 2,
    parameter int unsigned A_WIDTH = 12
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [1:0]         mode,
    input  logic [D_WIDTH-1:0] din,
    input  logic               din_vld,
    output logic               din_rdy,
    output logic [D_WIDTH-1:0] dout_sys,
    output logic [D_WIDTH-1:0] dout_itl,
    output logic               dout_vld,
    input  logic               dout_rdy,
    output logic               dout_sof,
    output logic               dout_eof,
    output logic               err_mode
);

    localparam int unsigned RA_W = A_WIDTH + 1;

    bank_st_e           bank_st   [2];
    logic [1:0]         bank_mode [2];
    logic               wr_bank;
    logic               rd_bank;
    logic [A_WIDTH-1:0] wr_cnt;
    logic [A_WIDTH-1:0] rd_cnt;

    logic               s0_vld;
    logic [A_WIDTH-1:0] s0_idx;
    logic [A_WIDTH-1:0] s0_rom;
    logic               s0_first;
    logic               s0_last;

    logic [D_WIDTH-1:0] ram_itl;

    // Write-side decode
    bank_st_e           wr_st;
    logic               wr_empty;
    logic               mode_bad;
    logic               wr_fire;
    logic [1:0]         wr_mode;
    logic               wr_last;

    assign wr_st    = bank_st[wr_bank];
    assign wr_empty = (wr_st == BANK_EMPTY);
    assign mode_bad = (mode == MODE_RSVD);
    assign din_rdy  = (wr_empty && !mode_bad) || (wr_st == BANK_FILLING);
    assign wr_fire  = din_vld && din_rdy;
    assign wr_mode  = wr_empty ? mode : bank_mode[wr_bank];
    assign wr_last  = (wr_cnt == A_WIDTH'(pb_len(wr_mode) - 1));

    // Read-side decode
    bank_st_e           rd_st;
    logic [1:0]         rd_mode;
    logic [A_WIDTH-1:0] rd_len;
    logic               stall;
    logic               issue;
    logic               eof_take;
    logic [RA_W-1:0]    rom_addr;

    assign rd_st    = bank_st[rd_bank];
    assign rd_mode  = bank_mode[rd_bank];
    assign rd_len   = A_WIDTH'(pb_len(rd_mode));
    assign stall    = dout_vld && !dout_rdy;
    assign issue    = !stall && ((rd_st == BANK_FULL) || (rd_st == BANK_DRAINING))
                      && (rd_cnt < rd_len);
    assign eof_take = dout_vld && dout_rdy && dout_eof;
    assign rom_addr = RA_W'(rd_cnt) + RA_W'(pb_base(rd_mode));

    // Bank lifecycle; writer and reader never touch the same bank in one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]   <= BANK_EMPTY;
                bank_mode[b] <= 2'd0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_fire && (wr_bank == 1'(b))) begin
                    if (wr_empty) begin
                        bank_mode[b] <= mode;
                    end
                    if (wr_last) begin
                        bank_st[b] <= BANK_FULL;
                    end else if (wr_empty) begin
                        bank_st[b] <= BANK_FILLING;
                    end
                end
                if (issue && (rd_bank == 1'(b)) && (bank_st[b] == BANK_FULL)) begin
                    bank_st[b] <= BANK_DRAINING;
                end
                if (eof_take && (rd_bank == 1'(b))) begin
                    bank_st[b] <= BANK_EMPTY;
                end
            end
        end
    end

    // Write counter, bank pointer and reserved-mode error pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            err_mode <= 1'b0;
        end else begin
            err_mode <= din_vld && wr_empty && mode_bad;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + A_WIDTH'(1);
                end
            end
        end
    end

    // Read counter, S0 (table lookup) and output control registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_cnt   <= '0;
            rd_bank  <= 1'b0;
            s0_vld   <= 1'b0;
            s0_idx   <= '0;
            s0_rom   <= '0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            dout_vld <= 1'b0;
            dout_sof <= 1'b0;
            dout_eof <= 1'b0;
        end else begin
            if (eof_take) begin
                rd_cnt  <= '0;
                rd_bank <= ~rd_bank;
            end else if (issue) begin
                rd_cnt <= rd_cnt + A_WIDTH'(1);
            end
            if (!stall) begin
                s0_vld <= issue;
                if (issue) begin
                    s0_idx   <= rd_cnt;
                    s0_rom   <= A_WIDTH'(itl_rom(32'(rom_addr)));
                    s0_first <= (rd_cnt == '0);
                    s0_last  <= (rd_cnt == rd_len - A_WIDTH'(1));
                end
                dout_vld <= s0_vld;
                dout_sof <= s0_vld && s0_first;
                dout_eof <= s0_vld && s0_last;
            end
        end
    end

    // S1: both reads come from the draining bank, which cannot change mid-frame.
    hpgp_itl_bank_ram #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_ram (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr_en     (wr_fire),
        .wr_addr   ({wr_bank, wr_cnt}),
        .wr_data   (din),
        .rd_en     (!stall),
        .rd_addr_a ({rd_bank, s0_idx}),
        .rd_addr_b ({rd_bank, s0_rom}),
        .rd_data_a (dout_sys),
        .rd_data_b (ram_itl)
    );

`ifdef HPGP_ITL_PAIR_SWAP_EN
    logic s0_even;
    logic itl_even;

    // Output-index parity follows the symbol through the pipeline.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s0_even  <= 1'b0;
            itl_even <= 1'b0;
        end else if (!stall) begin
            if (issue) begin
                s0_even <= ~rd_cnt[0];
            end
            itl_even <= s0_vld && s0_even;
        end
    end

    // Bit-reverse the interleaved symbol on even indices.
    always_comb begin
        dout_itl = ram_itl;
        if (itl_even) begin
            for (int k = 0; k < D_WIDTH; k++) begin
                dout_itl[k] = ram_itl[D_WIDTH-1-k];
            end
        end
    end
`else
    assign dout_itl = ram_itl;
`endif

endmodule

// File: tb/tb_hpgp_itl_pingpong.sv
// Scoreboard bench for hpgp_itl_pingpong: the driver pushes each completed
// frame's expected beats; a monitor pops and compares on every output handshake.
module tb_hpgp_itl_pingpong;

    localparam int unsigned D_WIDTH = 2;
    localparam int unsigned A_WIDTH = 12;
    localparam int          BOUND   = 6000;

    logic               clk = 1'b0;
    logic               n_rst;
    logic [1:0]         mode;
    logic [D_WIDTH-1:0] din;
    logic               din_vld;
    logic               din_rdy;
    logic [D_WIDTH-1:0] dout_sys;
    logic [D_WIDTH-1:0] dout_itl;
    logic               dout_vld;
    logic               dout_rdy;
    logic               dout_sof;
    logic               dout_eof;
    logic               err_mode;

    typedef struct packed {
        logic [1:0] sys;
        logic [1:0] itl;
        logic       sof;
        logic       eof;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   wr_done = 0;
    int   rd_done = 0;
    bit   occ_en  = 1'b0;
    bit   rdy_rand = 1'b0;

    hpgp_itl_pingpong #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .mode     (mode),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .dout_sys (dout_sys),
        .dout_itl (dout_itl),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .dout_sof (dout_sof),
        .dout_eof (dout_eof),
        .err_mode (err_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: frame length and affine permutation per PB size.
    function automatic int len_of(input int m);
        return (m == 0) ? 64 : (m == 1) ? 544 : 2080;
    endfunction

    function automatic int perm(input int m, input int i);
        int step;
        int off;
        if (m == 0)      begin step = 13; off = 5;  end
        else if (m == 1) begin step = 31; off = 11; end
        else             begin step = 97; off = 29; end
        return (step * i + off) % len_of(m);
    endfunction

    function automatic logic [1:0] swp(input logic [1:0] v, input int i);
`ifdef HPGP_ITL_PAIR_SWAP_EN
        return (i % 2 == 0) ? {v[0], v[1]} : v;
`else
        if (i < 0) return 2'b00;
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 'h%0h required 'h%0h at %0t", name, act, req, $time);
        end
    endtask

    // Output back-pressure generator
    initial begin
        dout_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dout_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: occupancy rule, no intra-frame gaps, stall hold, scoreboard pop.
    initial begin
        bit        prev_stall = 1'b0;
        bit        prev_mid   = 1'b0;
        logic [6:0] prev_out  = '0;
        logic [6:0] cur_out;
        exp_t      e;
        forever begin
            @(negedge clk);
            cur_out = {dout_vld, dout_sys, dout_itl, dout_sof, dout_eof};
            if (!n_rst) begin
                prev_stall = 1'b0;
                prev_mid   = 1'b0;
            end else begin
                if (occ_en && mode != 2'd3)
                    chk("din_rdy_vs_occupancy", int'(din_rdy), int'((wr_done - rd_done) < 2));
                if (prev_mid)
                    chk("no_gap_in_frame", int'(dout_vld), 1);
                if (prev_stall)
                    chk("stall_hold", int'(cur_out), int'(prev_out));
                if (dout_vld && dout_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got sys=%0d itl=%0d with no beat expected",
                                 dout_sys, dout_itl);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", int'({dout_sys, dout_itl, dout_sof, dout_eof}), int'(e));
                    end
                    if (dout_eof) rd_done++;
                end
                prev_stall = dout_vld && !dout_rdy;
                prev_mid   = dout_vld && dout_rdy && !dout_eof;
                prev_out   = cur_out;
            end
        end
    end

    // Send up to nbeats of a frame; a complete frame pushes its expected beats.
    task automatic send_frame(input int m, input bit rnd, input bit jitter,
                              input int nbeats, output bit ok);
        int         len;
        int         n;
        logic [1:0] d [];
        len = len_of(m);
        ok  = 1'b1;
        d   = new[len];
        for (int i = 0; i < len; i++) d[i] = rnd ? 2'($urandom) : 2'(i % 4);
        n = (nbeats < len) ? nbeats : len;
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc     = 1'b0;
            din     = d[i];
            din_vld = 1'b1;
            mode    = (jitter && i > 0) ? 2'($urandom_range(0, 3)) : 2'(m);
            for (int t = 0; t < BOUND && !acc; t++) begin
                @(negedge clk);
                acc = din_rdy;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL din_accept: beat %0d not accepted, required within %0d cycles", i, BOUND);
                ok = 1'b0;
                break;
            end
        end
        din_vld = 1'b0;
        mode    = 2'(m);
        if (ok && n == len) begin
            for (int i = 0; i < len; i++) begin
                exp_t e;
                e.sys = d[i];
                e.itl = swp(d[perm(m, i)], i);
                e.sof = (i == 0);
                e.eof = (i == len - 1);
                exp_q.push_back(e);
            end
            wr_done++;
        end
    endtask

    task automatic drain(input int bound);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("drain_complete", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_after_drain", int'(dout_vld), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        n_rst   = 1'b0;
        din_vld = 1'b0;
        #1;
        chk("reset_outputs_zero",
            int'({dout_vld, dout_sof, dout_eof, err_mode, dout_sys, dout_itl}), 0);
        exp_q.delete();
        wr_done = 0;
        rd_done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int lat;
        int ecnt;
        bit seen;
        n_rst   = 1'b1;
        mode    = 2'd0;
        din     = '0;
        din_vld = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk("reset_outputs_zero",
            int'({dout_vld, dout_sof, dout_eof, err_mode, dout_sys, dout_itl}), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", int'(din_rdy), 1);
        @(posedge clk);
        #1;

        // PB16 counting pattern and first-output latency
        send_frame(0, 1'b0, 1'b0, 64, ok);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            seen = dout_vld;
        end
        chk("first_out_latency", lat, 3);
        @(posedge clk);
        #1;
        drain(200);

        // Reserved mode at frame start
        mode    = 2'd3;
        din_vld = 1'b1;
        ecnt    = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rsvd_din_rdy", int'(din_rdy), 0);
            ecnt += int'(err_mode);
            @(posedge clk);
            #1;
        end
        din_vld = 1'b0;
        mode    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ecnt += int'(err_mode);
        end
        chk("err_mode_pulses", ecnt, 5);
        @(posedge clk);
        #1;
        send_frame(0, 1'b1, 1'b0, 64, ok);
        drain(200);

        // Three PB520 frames back-to-back
        occ_en = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(2, 1'b1, 1'b0, 2080, ok);
        drain(8000);

        // PB136 with random back-pressure and mode changes mid-frame, then mixed sizes
        rdy_rand = 1'b1;
        send_frame(1, 1'b1, 1'b1, 544, ok);
        send_frame(1, 1'b1, 1'b1, 544, ok);
        send_frame(0, 1'b1, 1'b1, 64, ok);
        send_frame(2, 1'b1, 1'b0, 2080, ok);
        send_frame(1, 1'b1, 1'b0, 544, ok);
        drain(20000);
        rdy_rand = 1'b0;
        occ_en   = 1'b0;

        // Reset mid-fill
        send_frame(2, 1'b1, 1'b0, 1000, ok);
        do_reset();
        send_frame(0, 1'b1, 1'b0, 64, ok);
        drain(200);

        // Reset mid-drain
        send_frame(2, 1'b1, 1'b0, 2080, ok);
        repeat (50) @(negedge clk);
        chk("pre_reset_draining", int'(dout_vld), 1);
        do_reset();
        send_frame(0, 1'b1, 1'b0, 64, ok);
        drain(200);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
